// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: ISA opcodes, addressing modes and sequencer states.
// Word layout: opcode[15:11], field1[10:8], field2[7:5], addrm[1:0].
package cpu_isa_pkg;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,  OP_MOV = 5'd1,  OP_LDR = 5'd2,  OP_LDI = 5'd3,
        OP_STR = 5'd4,  OP_ADD = 5'd5,  OP_SUB = 5'd6,  OP_ADC = 5'd7,
        OP_INC = 5'd8,  OP_DEC = 5'd9,  OP_AND = 5'd10, OP_OR  = 5'd11,
        OP_XOR = 5'd12, OP_NOT = 5'd13, OP_JMP = 5'd14, OP_JZ  = 5'd15,
        OP_JNZ = 5'd16, OP_JC  = 5'd17, OP_JNC = 5'd18, OP_HLT = 5'd31
    } opcode_e;

    typedef enum logic [1:0] {
        AM_NONE = 2'd0, AM_IMM = 2'd1, AM_REG = 2'd2, AM_DIR = 2'd3
    } addrm_e;

    typedef enum logic [3:0] {
        S_FETCH_PC, S_FETCH_INST, S_DECODE, S_MEM_R, S_MEM_W,
        S_ALU, S_WB, S_JMP, S_NEXT, S_HALT
    } state_e;

    localparam int ADDRM_W = 2;

endpackage

// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: sequencer-to-datapath/memory signal bundle.
interface control_unit_mc_if #(
    parameter int INSTR_W = 16,
    parameter int RSEL_W  = 3,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instr_i;
    logic               cflag_i, zflag_i, imem_ack_i, dmem_ack_i, resume_i;
    logic               pc_inc_o, pc_load_o, imar_we_o, imem_rd_o, ir_we_o;
    logic               dmar_we_o, dmem_rd_o, dmem_wr_o, alu_en_o, reg_rd_o, reg_wr_o;
    logic [RSEL_W-1:0]  reg_sel_in_o, reg_sel_out_o;
    logic               halted_o, timeout_o, illegal_o;
    logic [3:0]         state_o;
    logic [CNT_W-1:0]   retired_o;

    modport master (
        input  instr_i, cflag_i, zflag_i, imem_ack_i, dmem_ack_i, resume_i,
        output pc_inc_o, pc_load_o, imar_we_o, imem_rd_o, ir_we_o, dmar_we_o,
               dmem_rd_o, dmem_wr_o, alu_en_o, reg_rd_o, reg_wr_o,
               reg_sel_in_o, reg_sel_out_o, halted_o, timeout_o, illegal_o,
               state_o, retired_o
    );

    modport slave (
        output instr_i, cflag_i, zflag_i, imem_ack_i, dmem_ack_i, resume_i,
        input  pc_inc_o, pc_load_o, imar_we_o, imem_rd_o, ir_we_o, dmar_we_o,
               dmem_rd_o, dmem_wr_o, alu_en_o, reg_rd_o, reg_wr_o,
               reg_sel_in_o, reg_sel_out_o, halted_o, timeout_o, illegal_o,
               state_o, retired_o
    );
endinterface

// File: rtl/cu_wait_watchdog.sv
// cu_wait_watchdog: counts unacknowledged wait cycles and flags a sticky bus timeout.
module cu_wait_watchdog #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic ack,
    output logic expire,
    output logic timeout
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of earlier waiting cycles, so the WAIT_MAX-th one still accepts ack
    assign expire = waiting && !ack && cnt == CW'(WAIT_MAX - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= (waiting && !ack && !expire) ? cnt + CW'(1) : '0;
            timeout <= timeout | expire;
        end
    end
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle CPU sequencer with memory ack handshakes,
// bus-timeout watchdog, resumable halt and retired-instruction counter.
module control_unit_mc
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int OPC_W    = 5,
    parameter int RSEL_W   = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    control_unit_mc_if.master bus
);
    state_e            state;
    logic [OPC_W-1:0]  op;
    addrm_e            addrm;
    logic [RSEL_W-1:0] f1, f2;
    logic [CNT_W-1:0]  retired;
    logic              is_mov, mov_reg, mem_rd, is_alu, is_jmp, illegal, taken;
    logic              waiting, ack, expire;

    assign is_mov  = op == OP_MOV;
    assign mov_reg = is_mov && addrm == AM_REG;
    assign mem_rd  = op == OP_LDR || (is_mov && addrm == AM_DIR);
    assign is_alu  = op >= OP_ADD && op <= OP_NOT;
    assign is_jmp  = op >= OP_JMP && op <= OP_JNC;
    assign illegal = !(op <= OP_JNC || op == OP_HLT);
    assign taken   = op == OP_JMP || (op == OP_JZ && bus.zflag_i) || (op == OP_JNZ && !bus.zflag_i)
                  || (op == OP_JC && bus.cflag_i) || (op == OP_JNC && !bus.cflag_i);

    assign waiting = state == S_FETCH_INST || state == S_MEM_R || state == S_MEM_W;
    assign ack     = state == S_FETCH_INST ? bus.imem_ack_i : bus.dmem_ack_i;

    cu_wait_watchdog #(.WAIT_MAX(WAIT_MAX)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .waiting (waiting),
        .ack     (ack),
        .expire  (expire),
        .timeout (bus.timeout_o)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH_PC;
            op      <= '0;
            addrm   <= AM_NONE;
            f1      <= '0;
            f2      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH_PC: state <= S_FETCH_INST;
                S_FETCH_INST: begin
                    if (ack) begin
                        state <= S_DECODE;
                        op    <= bus.instr_i[INSTR_W-1 -: OPC_W];
                        f1    <= bus.instr_i[INSTR_W-OPC_W-1 -: RSEL_W];
                        f2    <= bus.instr_i[INSTR_W-OPC_W-RSEL_W-1 -: RSEL_W];
                        addrm <= addrm_e'(bus.instr_i[ADDRM_W-1:0]);
                    end else if (expire) begin
                        state <= S_HALT;
                    end
                end
                S_DECODE: state <= op == OP_HLT ? S_HALT :
                                   mem_rd ? S_MEM_R :
                                   op == OP_STR ? S_MEM_W :
                                   (is_mov || op == OP_LDI) ? S_WB :
                                   is_alu ? S_ALU :
                                   is_jmp ? S_JMP : S_NEXT;
                S_MEM_R: state <= ack ? S_WB : expire ? S_HALT : S_MEM_R;
                S_MEM_W: state <= ack ? S_NEXT : expire ? S_HALT : S_MEM_W;
                S_ALU: state <= S_WB;
                S_WB, S_JMP: state <= S_NEXT;
                S_NEXT: begin
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH_PC;
                end
                S_HALT: state <= bus.resume_i ? S_NEXT : S_HALT;
                default: state <= S_FETCH_PC;
            endcase
        end
    end

    // Strobes are decoded from the registered state and the latched instruction fields
    assign bus.pc_inc_o      = state == S_FETCH_PC;
    assign bus.imar_we_o     = state == S_FETCH_PC;
    assign bus.imem_rd_o     = state == S_FETCH_INST;
    assign bus.ir_we_o       = state == S_FETCH_INST && bus.imem_ack_i;
    assign bus.dmar_we_o     = state == S_DECODE && (mem_rd || op == OP_STR);
    assign bus.illegal_o     = state == S_DECODE && illegal;
    assign bus.dmem_rd_o     = state == S_MEM_R;
    assign bus.dmem_wr_o     = state == S_MEM_W;
    assign bus.alu_en_o      = state == S_ALU;
    assign bus.reg_rd_o      = state == S_MEM_W || state == S_ALU || (state == S_WB && mov_reg);
    assign bus.reg_wr_o      = state == S_WB;
    assign bus.pc_load_o     = state == S_JMP && taken;
    assign bus.halted_o      = state == S_HALT;
    assign bus.reg_sel_in_o  = is_mov ? f2 : f1;
    assign bus.reg_sel_out_o = (mov_reg || op == OP_STR) ? f1 : '0;
    assign bus.state_o       = state;
    assign bus.retired_o     = retired;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: random instruction stream checked cycle by cycle against
// a timeline expanded from the ISA's per-instruction state/strobe sequences.
module tb_control_unit_mc;
    import cpu_isa_pkg::*;

    localparam int WMAX = 15;
    localparam logic [11:0] PLD = 12'h400, PINC = 12'h800, IMAR = 12'h200, IMRD = 12'h100,
                            IRWE = 12'h080, DMAR = 12'h040, DMRD = 12'h020, DMWR = 12'h010,
                            ALU = 12'h008, RRD = 12'h004, RWR = 12'h002, ILL = 12'h001;

    typedef struct {
        logic [3:0]  st;
        logic [11:0] strb;
        logic [2:0]  sin, sout;
        logic        halted, tmo;
        logic [15:0] ret, ins;
        logic        iack, dack, res, z, c, rn;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0, n_pass = 0, cyc = 0;
    cyc_t q[$];
    logic [15:0] m_ret = '0;
    logic        m_tmo = 1'b0;
    logic [2:0]  m_sin = '0, m_sout = '0;

    control_unit_mc_if #(.INSTR_W(16), .RSEL_W(3), .CNT_W(16)) bus ();

    control_unit_mc #(.INSTR_W(16), .OPC_W(5), .RSEL_W(3), .WAIT_MAX(WMAX), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // -1 on any drive argument means "random noise"
    task automatic push(input state_e st, input logic [11:0] strb, input int iack = -1, input int dack = -1,
                        input int res = -1, input int z = -1, input int c = -1, input int ins = -1,
                        input int rn = 1);
        cyc_t r;
        r.st = st; r.strb = strb; r.sin = m_sin; r.sout = m_sout;
        r.halted = st == S_HALT; r.tmo = m_tmo; r.ret = m_ret;
        r.iack = iack < 0 ? 1'($urandom) : 1'(iack);
        r.dack = dack < 0 ? 1'($urandom) : 1'(dack);
        r.res  = res  < 0 ? 1'($urandom) : 1'(res);
        r.z    = z    < 0 ? 1'($urandom) : 1'(z);
        r.c    = c    < 0 ? 1'($urandom) : 1'(c);
        r.ins  = ins  < 0 ? 16'($urandom) : 16'(ins);
        r.rn   = 1'(rn);
        q.push_back(r);
    endtask

    task automatic next_seq();
        push(S_NEXT, 12'h0);
        m_ret = m_ret + 16'd1;
    endtask

    task automatic halt_seq(input int hw);
        repeat (hw) push(S_HALT, 12'h0, -1, -1, 0);
        push(S_HALT, 12'h0, -1, -1, 1);
        next_seq();
    endtask

    // Expand one instruction into its expected cycles; kill = memory wait cycle that pulls reset low
    task automatic plan(input int op, input int am, input int a, input int b, input int id, input int dd,
                        input int hw, input int fz, input int fc, input int kill);
        logic [15:0] w;
        logic [11:0] sb;
        state_e st;
        bit mov, mrd, str, alu, jmp, ill, tk;
        int z, c;
        w   = {op[4:0], a[2:0], b[2:0], 3'b000, am[1:0]};
        mov = op == 1; str = op == 4; mrd = op == 2 || (mov && am == 3);
        alu = op >= 5 && op <= 13; jmp = op >= 14 && op <= 18; ill = op > 18 && op < 31;
        push(S_FETCH_PC, PINC | IMAR);
        for (int i = 0; i < id && i < WMAX; i++) push(S_FETCH_INST, IMRD, 0);
        if (id >= WMAX) begin
            m_tmo = 1'b1;
            halt_seq(hw);
            return;
        end
        push(S_FETCH_INST, IMRD | IRWE, 1, -1, -1, -1, -1, int'(w));
        m_sin  = 3'(mov ? b : a);
        m_sout = ((mov && am == 2) || str) ? 3'(a) : 3'd0;
        push(S_DECODE, ((mrd || str) ? DMAR : 12'h0) | (ill ? ILL : 12'h0));
        if (op == 31) begin
            halt_seq(hw);
            return;
        end
        if (mrd || str) begin
            st = mrd ? S_MEM_R : S_MEM_W;
            sb = mrd ? DMRD : (DMWR | RRD);
            for (int i = 0; i < dd && i < WMAX; i++) begin
                if (i + 1 == kill) begin
                    push(st, sb, -1, 0, -1, -1, -1, -1, 0);
                    m_ret = '0; m_tmo = 1'b0; m_sin = '0; m_sout = '0;
                    return;
                end
                push(st, sb, -1, 0);
            end
            if (dd >= WMAX) begin
                m_tmo = 1'b1;
                halt_seq(hw);
                return;
            end
            push(st, sb, -1, 1);
            if (mrd) push(S_WB, RWR);
        end else if (mov || op == 3) begin
            push(S_WB, RWR | ((mov && am == 2) ? RRD : 12'h0));
        end else if (alu) begin
            push(S_ALU, ALU | RRD);
            push(S_WB, RWR);
        end else if (jmp) begin
            z  = fz < 0 ? int'($urandom_range(0, 1)) : fz;
            c  = fc < 0 ? int'($urandom_range(0, 1)) : fc;
            tk = op == 14 || (op == 15 && z != 0) || (op == 16 && z == 0) || (op == 17 && c != 0) || (op == 18 && c == 0);
            push(S_JMP, tk ? PLD : 12'h0, -1, -1, -1, z, c);
        end
        next_seq();
    endtask

    function automatic int rdelay();
        return $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        cyc_t r;
        plan(OP_ADD, 0, 1, 2, 0, 0, 0, -1, -1, 0);
        plan(OP_LDR, 0, 3, 0, 0, 3, 0, -1, -1, 0);
        plan(OP_JZ, 0, 0, 0, 0, 0, 0, 1, -1, 0);
        plan(OP_JZ, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        plan(OP_NOP, 0, 0, 0, 15, 0, 3, -1, -1, 0);
        plan(OP_NOP, 0, 0, 0, 1, 0, 0, -1, -1, 0);
        plan(OP_HLT, 0, 0, 0, 0, 0, 10, -1, -1, 0);
        plan(OP_MOV, AM_DIR, 2, 6, 1, 1, 0, -1, -1, 0);
        plan(OP_MOV, AM_REG, 4, 7, 0, 0, 0, -1, -1, 0);
        plan(OP_LDR, 0, 5, 0, 0, 15, 1, -1, -1, 0);
        plan(OP_STR, 0, 5, 0, 0, 6, 0, -1, -1, 3);
        plan(20, 0, 6, 1, 0, 0, 0, -1, -1, 0);
        for (int k = 0; k < 150; k++) begin
            int op;
            op = $urandom_range(0, 9) == 0 ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18));
            plan(op, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                 rdelay(), rdelay(), $urandom_range(0, 3), -1, -1, 0);
        end
        {bus.instr_i, bus.cflag_i, bus.zflag_i, bus.imem_ack_i, bus.dmem_ack_i, bus.resume_i} = '0;
        repeat (2) @(posedge clk);
        #1;
        foreach (q[k]) begin
            r = q[k];
            cyc = k;
            reset = r.rn;
            bus.instr_i = r.ins; bus.imem_ack_i = r.iack; bus.dmem_ack_i = r.dack;
            bus.resume_i = r.res; bus.zflag_i = r.z; bus.cflag_i = r.c;
            @(negedge clk);
            check("state", 32'(bus.state_o), 32'(r.st));
            check("strobes", 32'({bus.pc_inc_o, bus.pc_load_o, bus.imar_we_o, bus.imem_rd_o, bus.ir_we_o,
                                  bus.dmar_we_o, bus.dmem_rd_o, bus.dmem_wr_o, bus.alu_en_o, bus.reg_rd_o,
                                  bus.reg_wr_o, bus.illegal_o}), 32'(r.strb));
            check("halted", 32'(bus.halted_o), 32'(r.halted));
            check("timeout", 32'(bus.timeout_o), 32'(r.tmo));
            check("retired", 32'(bus.retired_o), 32'(r.ret));
            check("sel_in", 32'(bus.reg_sel_in_o), 32'(r.sin));
            check("sel_out", 32'(bus.reg_sel_out_o), 32'(r.sout));
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
